// File: rtl/result_collector.sv
// Result collector: captures matrix-multiplier rows into a ping-pong tile buffer, requantises
// them and streams one row per valid/ready beat. Define RESULT_COLLECTOR_RELU_EN to clamp
// negative outputs to zero.
module result_collector #(
  parameter int unsigned N           = 4,
  parameter int unsigned RESULT_SIZE = 32,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned SHIFT       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N*RESULT_SIZE-1:0] row_data,
  input  logic [1:0]               row_done,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N*OUT_WIDTH-1:0]   out_data,
  output logic [$clog2(N)-1:0]     out_row_idx,
  output logic                     out_last,
  output logic                     overflow
);

  localparam int unsigned RowW = N * RESULT_SIZE;
  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(N + 1);
  localparam int unsigned VW   = RESULT_SIZE + 1;

`ifdef RESULT_COLLECTOR_RELU_EN
  localparam bit ReluEn = 1'b1;
`else
  localparam bit ReluEn = 1'b0;
`endif

  localparam logic [VW:0]           RoundWide = ({{VW{1'b0}}, 1'b1} << SHIFT) >> 1;
  localparam logic signed [VW-1:0]  RoundV    = RoundWide[VW-1:0];
  localparam logic [OUT_WIDTH-1:0]  MaxOut    = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic [OUT_WIDTH-1:0]  MinOut    = {1'b1, {(OUT_WIDTH-1){1'b0}}};
  localparam logic signed [VW-1:0]  MaxV      = {{(VW-OUT_WIDTH){1'b0}}, MaxOut};
  localparam logic signed [VW-1:0]  MinV      = {{(VW-OUT_WIDTH){1'b1}}, MinOut};

  typedef logic [RowW-1:0] row_t;
  typedef enum logic [0:0] {StIdle, StSend} state_e;

  row_t mem_q [2][N];
  row_t mem_d [2][N];

  logic [1:0]      full_q, full_d;
  logic [CntW-1:0] cnt_q [2];
  logic [CntW-1:0] cnt_d [2];
  logic            wr_bank_q, wr_bank_d;
  logic [CntW-1:0] wr_row_q, wr_row_d;
  logic            rd_bank_q, rd_bank_d;
  logic [IdxW-1:0] rd_row_q, rd_row_d;
  logic            overflow_q, overflow_d;

  logic [N*OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;

  state_e state_q, state_d;

  logic            wr_accept, wr_close;
  logic            load, rd_release;
  logic [IdxW-1:0] load_idx;
  logic [CntW-1:0] rd_cnt;
  logic            at_last;

  row_t                   sel_row;
  logic [N*OUT_WIDTH-1:0] quant_row;
  logic [RESULT_SIZE-1:0] elem;
  logic signed [VW-1:0]   v_rnd, v_sh;
  logic [OUT_WIDTH-1:0]   q_el;

  // ---------------------------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------------------------
  // A row is only accepted into an empty bank that still has room; wr_row==N means the producer
  // never closed the tile.
  assign wr_accept = row_done[0] && !full_q[wr_bank_q] && (wr_row_q != CntW'(N));
  assign wr_close  = wr_accept && row_done[1];

  always_comb begin
    mem_d = mem_q;
    if (wr_accept) begin
      mem_d[wr_bank_q][wr_row_q[IdxW-1:0]] = row_data;
    end
  end

  always_comb begin
    wr_row_d   = wr_row_q;
    wr_bank_d  = wr_bank_q;
    cnt_d      = cnt_q;
    full_d     = full_q;
    overflow_d = overflow_q | (row_done[0] & ~wr_accept);
    if (wr_accept) begin
      wr_row_d = wr_row_q + CntW'(1);
    end
    if (wr_close) begin
      full_d[wr_bank_q] = 1'b1;
      cnt_d[wr_bank_q]  = wr_row_q + CntW'(1);
      wr_bank_d         = ~wr_bank_q;
      wr_row_d          = '0;
    end
    // Close and release can never target the same bank: one needs it empty, the other full.
    if (rd_release) begin
      full_d[rd_bank_q] = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Read-side FSM
  // ---------------------------------------------------------------------------------------------
  assign rd_cnt  = cnt_q[rd_bank_q];
  assign at_last = (CntW'(rd_row_q) == rd_cnt - CntW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (full_q[rd_bank_q]) state_d = StSend;
      StSend: if (out_ready && at_last) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    load       = 1'b0;
    load_idx   = '0;
    rd_release = 1'b0;
    out_valid  = (state_q == StSend);
    unique case (state_q)
      StIdle: begin
        if (full_q[rd_bank_q]) begin
          load = 1'b1;
        end
      end
      StSend: begin
        if (out_ready) begin
          if (at_last) begin
            rd_release = 1'b1;
          end else begin
            load     = 1'b1;
            load_idx = rd_row_q + IdxW'(1);
          end
        end
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Requantisation of the row about to be loaded
  // ---------------------------------------------------------------------------------------------
  assign sel_row = mem_q[rd_bank_q][load_idx];

  always_comb begin
    quant_row = '0;
    elem      = '0;
    v_rnd     = '0;
    v_sh      = '0;
    q_el      = '0;
    for (int k = 0; k < int'(N); k++) begin
      elem  = sel_row[RowW-1-k*RESULT_SIZE -: RESULT_SIZE];
      // One extra bit keeps the rounding add from wrapping at the positive extreme.
      v_rnd = $signed({elem[RESULT_SIZE-1], elem}) + RoundV;
      v_sh  = v_rnd >>> SHIFT;
      if (v_sh > MaxV) begin
        q_el = MaxOut;
      end else if (v_sh < MinV) begin
        q_el = MinOut;
      end else begin
        q_el = v_sh[OUT_WIDTH-1:0];
      end
      if (ReluEn && q_el[OUT_WIDTH-1]) begin
        q_el = '0;
      end
      quant_row[N*OUT_WIDTH-1-k*OUT_WIDTH -: OUT_WIDTH] = q_el;
    end
  end

  always_comb begin
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    rd_row_d   = rd_row_q;
    rd_bank_d  = rd_bank_q;
    if (load) begin
      out_data_d = quant_row;
      rd_row_d   = load_idx;
      out_last_d = (CntW'(load_idx) == rd_cnt - CntW'(1));
    end
    if (rd_release) begin
      rd_row_d   = '0;
      out_last_d = 1'b0;
      rd_bank_d  = ~rd_bank_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  // Tile storage carries no reset; the full flags alone decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q     <= '0;
      cnt_q      <= '{default: '0};
      wr_bank_q  <= 1'b0;
      wr_row_q   <= '0;
      rd_bank_q  <= 1'b0;
      rd_row_q   <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
      out_last_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      cnt_q      <= cnt_d;
      wr_bank_q  <= wr_bank_d;
      wr_row_q   <= wr_row_d;
      rd_bank_q  <= rd_bank_d;
      rd_row_q   <= rd_row_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
      out_last_q <= out_last_d;
    end
  end

  assign out_data    = out_data_q;
  assign out_row_idx = rd_row_q;
  assign out_last    = out_last_q;
  assign overflow    = overflow_q;

endmodule
